// File: rtl/hwag_tooth_capture.sv
// hwag_tooth_capture: crank tooth synchroniser, period capture, gap detection and tooth tracking.
// Tooth events are timed with a saturating counter; saturation stalls the engine back to IDLE.
module hwag_tooth_capture #(
    parameter int WIDTH    = 24,
    parameter int TEETH    = 58,
    parameter int TN_WIDTH = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                vr_in,
    input  logic                edge_sel,
    output logic [WIDTH-1:0]    cap0,
    output logic [WIDTH-1:0]    cap1,
    output logic                gap,
    output logic [TN_WIDTH-1:0] tooth_num,
    output logic                sync,
    output logic                cap_stb,
    output logic                div_start,
    output logic                sync_err,
    output logic                stall
);
    localparam logic [WIDTH-1:0]    MAX  = '1;
    localparam logic [TN_WIDTH-1:0] LAST = TN_WIDTH'(TEETH - 1);

    typedef enum logic [1:0] {IDLE, PRIME, SEARCH, SYNC} state_t;

    state_t              state, state_n;
    logic                s1, s2, s3;
    logic [WIDTH-1:0]    tmr;
    logic [TN_WIDTH-1:0] tn_n;
    logic                evt, cap, gap_n, err_n, sat;

    assign evt       = edge_sel ? (s3 & ~s2) : (s2 & ~s3);
    // sat covers the edge on which tmr arrives at MAX as well as sitting there
    assign sat       = ~evt & (tmr >= MAX - 1'b1);
    assign cap       = evt & (tmr != MAX) & (state != IDLE);
    assign gap_n     = (state != PRIME) & ({1'b0, tmr} > {cap0, 1'b0});
    assign sync      = state == SYNC;
    assign div_start = (state == SEARCH || state == SYNC) & ~cap_stb;

    always_comb begin
        state_n = state;
        tn_n    = tooth_num;
        err_n   = 1'b0;
        if (evt && (tmr == MAX || state == IDLE)) begin
            state_n = PRIME;
        end else if (evt) begin
            if (state == PRIME) begin
                state_n = SEARCH;
            end else if (gap_n) begin
                state_n = SYNC;
                tn_n    = '0;
                err_n   = state == SYNC && tooth_num != LAST;
            end else if (state == SYNC && tooth_num == LAST) begin
                state_n = SEARCH;
                err_n   = 1'b1;
            end else if (state == SYNC) begin
                tn_n = tooth_num + 1'b1;
            end
        end else if (sat) begin
            state_n = IDLE;
            tn_n    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {s3, s2, s1} <= '0;
            tmr          <= '0;
            state        <= IDLE;
            tooth_num    <= '0;
            cap0         <= '0;
            cap1         <= '0;
            gap          <= 1'b0;
            cap_stb      <= 1'b0;
            sync_err     <= 1'b0;
            stall        <= 1'b0;
        end else begin
            {s3, s2, s1} <= {s2, s1, vr_in};
            tmr          <= evt ? WIDTH'(1) : (tmr == MAX ? tmr : tmr + 1'b1);
            state        <= state_n;
            tooth_num    <= tn_n;
            cap_stb      <= cap;
            sync_err     <= err_n;
            stall        <= evt ? 1'b0 : (sat | stall);
            if (cap) begin
                cap1 <= cap0;
                cap0 <= tmr;
                gap  <= gap_n;
            end else if (sat) begin
                cap0 <= '0;
                cap1 <= '0;
                gap  <= 1'b0;
            end
        end
    end
endmodule
